// File: rtl/ps2k_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter and the scan-code receiver:
// FSM state encodings, keyboard command bytes and the frame parity helper.
package ps2k_tx_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StInhibit  = 3'd1,
        StRts      = 3'd2,
        StShift    = 3'd3,
        StAck      = 3'd4,
        StWaitIdle = 3'd5
    } ps2_state_e;

    // Host-to-device command bytes and the device acknowledge byte
    localparam logic [7:0] CmdSetLed = 8'hED;
    localparam logic [7:0] CmdEnable = 8'hF4;
    localparam logic [7:0] CmdReset  = 8'hFF;
    localparam logic [7:0] RespAck   = 8'hFA;

    // Bit index values seen in SHIFT: below BitIdxPar a data/parity bit is still queued,
    // at BitIdxPar the next fall releases the stop bit; the index saturates at BitIdxLast.
    localparam logic [3:0] BitIdxPar  = 4'd9;
    localparam logic [3:0] BitIdxLast = 4'd10;

    // PS/2 frames carry odd parity over the eight data bits
    function automatic logic odd_parity(input logic [7:0] value);
        return ~^value;
    endfunction

endpackage

// File: rtl/ps2k_tx_ckfilter.sv
// PS/2 clock conditioner: 8-sample majority-free shift filter with hysteresis plus a one-cycle
// pulse on every filtered high-to-low transition. The sample register doubles as synchroniser.
module ps2k_tx_ckfilter (
    input  logic clock,
    input  logic reset,
    input  logic ck_raw,
    output logic ck_filt,
    output logic fall
);

    logic [7:0] samp_q;
    logic       filt_q;
    logic       filt_d;
    logic       fall_q;

    // Sample history, filtered level and edge pulse; the idle bus is high, so reset to ones
    always_ff @(posedge clock) begin
        if (reset) begin
            samp_q <= '1;
            filt_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            samp_q <= {samp_q[6:0], ck_raw};
            filt_q <= filt_d;
            fall_q <= filt_q & ~filt_d;
        end
    end

    // Only a full run of identical samples moves the filtered level; anything else holds it
    always_comb begin
        filt_d = filt_q;
        if (&samp_q) begin
            filt_d = 1'b1;
        end else if (~|samp_q) begin
            filt_d = 1'b0;
        end
    end

    assign ck_filt = filt_q;
    assign fall    = fall_q;

endmodule

// File: rtl/ps2k_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send, shifts one
// command byte out on device clock falls and checks the device ACK bit.
module ps2k_tx
    import ps2k_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Ck,
    input  logic       ps2D,
    output logic       ps2CkOe,
    output logic       ps2DOe,
    input  logic       send,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned InhW = $clog2(INHIBIT_CYCLES);
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned CntW = (InhW > ToW) ? InhW : ToW;

    localparam logic [CntW-1:0] InhLast = CntW'(INHIBIT_CYCLES - 1);
    localparam logic [CntW-1:0] ToLast  = CntW'(TIMEOUT_CYCLES - 1);

    ps2_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [8:0]      sr_q, sr_d;
    logic [3:0]      n_q, n_d;
    logic            drive_q, drive_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            d_q;
    logic            ck_filt;
    logic            fall;
    logic            timeout;

    ps2k_tx_ckfilter u_ckfilter (
        .clock   (clock),
        .reset   (reset),
        .ck_raw  (ps2Ck),
        .ck_filt (ck_filt),
        .fall    (fall)
    );

    // State register plus datapath registers; data line is registered once
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sr_q    <= '0;
            n_q     <= '0;
            drive_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            d_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            n_q     <= n_d;
            drive_q <= drive_d;
            done_q  <= done_d;
            error_q <= error_d;
            d_q     <= ps2D;
        end
    end

    assign timeout = (cnt_q == ToLast);

    // Next-state logic; a timeout is checked before the fall so it wins a same-cycle race
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        n_d     = n_q;
        drive_d = drive_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d   = '0;
                drive_d = 1'b0;
                if (send) begin
                    sr_d    = {odd_parity(data), data};
                    n_d     = '0;
                    state_d = StInhibit;
                end
            end
            StInhibit: begin
                if (cnt_q == InhLast) begin
                    cnt_d   = '0;
                    state_d = StRts;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRts: begin
                cnt_d   = '0;
                n_d     = '0;
                drive_d = 1'b1;  // start bit stays low until the first device fall
                state_d = StShift;
            end
            StShift: begin
                if (timeout) begin
                    cnt_d   = '0;
                    drive_d = 1'b0;
                    error_d = 1'b1;
                    state_d = StIdle;
                end else if (fall) begin
                    cnt_d = '0;
                    n_d   = (n_q >= BitIdxLast) ? n_q : n_q + 4'd1;
                    if (n_q < BitIdxPar) begin
                        drive_d = ~sr_q[0];
                        sr_d    = {1'b0, sr_q[8:1]};
                    end else begin
                        drive_d = 1'b0;  // stop bit: release the line
                        state_d = StAck;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAck: begin
                if (timeout) begin
                    cnt_d   = '0;
                    error_d = 1'b1;
                    state_d = StIdle;
                end else if (fall) begin
                    cnt_d = '0;
                    if (!d_q) begin
                        state_d = StWaitIdle;
                    end else begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitIdle: begin
                if (timeout) begin
                    cnt_d   = '0;
                    error_d = 1'b1;
                    state_d = StIdle;
                end else if (ck_filt && d_q) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = fall ? '0 : cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Open-drain enables decoded from the registered state
    always_comb begin
        ps2CkOe = 1'b0;
        ps2DOe  = 1'b0;
        unique case (state_q)
            StInhibit: ps2CkOe = 1'b1;
            StRts: begin
                ps2CkOe = 1'b1;
                ps2DOe  = 1'b1;
            end
            StShift: ps2DOe = drive_q;
            default: ;
        endcase
    end

    assign busy  = (state_q != StIdle);
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_ps2k_tx.sv
// Bench for ps2k_tx: a device model clocks frames out of the DUT, expected outcomes are queued
// at send time and matched against pulses collected by a negedge monitor.
module tb_ps2k_tx;

    localparam int unsigned INH = 64;
    localparam int unsigned TMO = 1000;
    localparam int          H   = 25;  // device clock half period in system clocks

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       send  = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       dev_ck = 1'b1;
    logic       dev_d  = 1'b1;
    logic       ps2CkOe, ps2DOe, busy, done, error;
    logic       ck_line, d_line;

    assign ck_line = dev_ck & ~ps2CkOe;
    assign d_line  = dev_d & ~ps2DOe;

    ps2k_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .ps2Ck   (ck_line),
        .ps2D    (d_line),
        .ps2CkOe (ps2CkOe),
        .ps2DOe  (ps2DOe),
        .send    (send),
        .data    (data),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic done;
        logic error;
        logic busy;
        logic ckoe;
        logic doe;
        logic prev;
    } obs_t;

    typedef struct packed {
        logic [10:0] bits;
        logic        chk_bits;
        logic        done;
        logic        error;
    } exp_t;

    typedef struct packed {
        logic [7:0] d;
        logic       ack;
        logic       glitch;
        logic       resend;
        logic       par;
        logic       exp_done;
    } vec_t;

    obs_t obs_q[$];
    exp_t exp_q[$];
    vec_t vecs[5];
    logic prev_pulse = 1'b0;
    int   total = 0;
    int   bad   = 0;

    // Collect every done/error cycle, noting whether the previous cycle also pulsed
    always @(negedge clock) begin
        if (done || error) obs_q.push_back({done, error, busy, ps2CkOe, ps2DOe, prev_pulse});
        prev_pulse = done | error;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Send one byte and play the device side of the frame
    task automatic run_frame(input logic [7:0] d, input bit ack, input bit glitch,
                             input bit resend, input int abort_at,
                             output logic [10:0] bits, output int inh, output bit aborted);
        int guard;
        bits    = '1;
        inh     = 0;
        aborted = 0;
        guard   = 0;
        send = 1'b1;
        data = d;
        tick();
        send = 1'b0;
        while (ps2CkOe && guard < 5000) begin
            send = resend && (inh == 10);
            data = 8'h12;
            tick();
            inh++;
            guard++;
        end
        send = 1'b0;
        check("rts_seen", (inh > 0) && (guard < 5000), 1);
        repeat (H) tick();
        bits[0] = d_line;
        for (int k = 0; k < 11; k++) begin
            if (k == 10 && ack) dev_d = 1'b0;
            for (int c = 0; c < H; c++) begin
                dev_ck = (glitch && c == 15) ? 1'b1 : 1'b0;
                tick();
            end
            if (abort_at != 0 && k == abort_at - 1) begin
                dev_ck  = 1'b1;
                reset   = 1'b1;
                tick();
                aborted = 1;
                return;
            end
            dev_ck = 1'b1;
            if (k < 10) bits[k+1] = d_line;
            if (k == 10) dev_d = 1'b1;
            for (int c = 0; c < H; c++) begin
                dev_ck = (glitch && c == 15) ? 1'b0 : 1'b1;
                send   = resend && (k == 4) && (c == 0);
                data   = 8'h33;
                tick();
            end
            send = 1'b0;
        end
    endtask

    // Pop the expectation, wait for the outcome pulse and compare
    task automatic finish_frame(input string tag, input logic [10:0] bits, input int inh);
        exp_t e;
        obs_t o;
        int   guard;
        e = exp_q.pop_front();
        if (e.chk_bits) begin
            check({tag, "_inhibit_len"}, inh >= int'(INH), 1);
            check({tag, "_frame_bits"}, bits, e.bits);
        end
        guard = 0;
        while (obs_q.size() == 0 && guard < 2000) begin
            tick();
            guard++;
        end
        check({tag, "_outcome_seen"}, obs_q.size() != 0, 1);
        if (obs_q.size() != 0) begin
            o = obs_q.pop_front();
            check({tag, "_done_error"}, {o.done, o.error}, {e.done, e.error});
            check({tag, "_busy_at_end"}, o.busy, 0);
            check({tag, "_lines_released"}, {o.ckoe, o.doe}, 0);
            check({tag, "_single_pulse"}, o.prev, 0);
        end
        repeat (60) tick();
        check({tag, "_no_extra_activity"}, {obs_q.size(), busy, ps2CkOe}, 0);
        obs_q.delete();
    endtask

    initial begin
        logic [10:0] bits;
        int          inh;
        bit          aborted;
        int          n;

        vecs[0] = '{d: 8'hED, ack: 1'b1, glitch: 1'b0, resend: 1'b0, par: 1'b1, exp_done: 1'b1};
        vecs[1] = '{d: 8'h00, ack: 1'b1, glitch: 1'b0, resend: 1'b0, par: 1'b1, exp_done: 1'b1};
        vecs[2] = '{d: 8'h01, ack: 1'b1, glitch: 1'b0, resend: 1'b0, par: 1'b0, exp_done: 1'b1};
        vecs[3] = '{d: 8'hFF, ack: 1'b0, glitch: 1'b0, resend: 1'b0, par: 1'b1, exp_done: 1'b0};
        vecs[4] = '{d: 8'hF4, ack: 1'b1, glitch: 1'b1, resend: 1'b1, par: 1'b0, exp_done: 1'b1};

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_outputs", {ps2CkOe, ps2DOe, busy, done, error}, 0);
        obs_q.delete();

        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{bits: {1'b1, vecs[i].par, vecs[i].d, 1'b0}, chk_bits: 1'b1,
                              done: vecs[i].exp_done, error: ~vecs[i].exp_done});
            run_frame(vecs[i].d, vecs[i].ack, vecs[i].glitch, vecs[i].resend, 0,
                      bits, inh, aborted);
            finish_frame($sformatf("vec%0d", i), bits, inh);
        end

        // Device never clocks: error exactly TMO cycles after SHIFT entry
        exp_q.push_back('{bits: '0, chk_bits: 1'b0, done: 1'b0, error: 1'b1});
        send = 1'b1;
        data = 8'hF4;
        tick();
        send = 1'b0;
        n = 0;
        while (ps2CkOe && n < 5000) begin
            tick();
            n++;
        end
        n = 0;
        while (!error && n < int'(TMO) + 100) begin
            tick();
            n++;
        end
        check("timeout_latency", n, TMO);
        finish_frame("timeout", '0, 0);

        // Reset after the fifth fall, then a normal frame
        run_frame(8'hAA, 1'b1, 1'b0, 1'b0, 5, bits, inh, aborted);
        check("reset_mid_frame_outputs", {aborted, ps2CkOe, ps2DOe, busy, done, error}, 6'b100000);
        reset = 1'b0;
        repeat (20) tick();
        check("reset_mid_frame_no_pulse", obs_q.size(), 0);
        obs_q.delete();
        exp_q.push_back('{bits: {1'b1, 1'b1, 8'h55, 1'b0}, chk_bits: 1'b1, done: 1'b1,
                          error: 1'b0});
        run_frame(8'h55, 1'b1, 1'b0, 1'b0, 0, bits, inh, aborted);
        finish_frame("after_reset_55", bits, inh);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
